// File: rtl/cordic_rotator.sv
// cordic_rotator: fully pipelined rotation-mode CORDIC.
//
// Rotates a signed (xi, yi) vector by the phase zi, where a full circle is
// 2^ZWIDTH. One sample is accepted every clock with no backpressure. stb_in
// travels along a valid chain that runs beside the data pipeline. The data
// registers load every cycle whatever is on the inputs.
//
// Pipeline, one register each:
//   capture -> pre-rotation -> STAGES micro-rotations -> output
// This gives a latency of STAGES+2 clocks from the capture edge to stb_out.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset; clears every register
//   xi, yi   signed input vector, WIDTH bits
//   zi       rotation angle, unsigned modulo 2^ZWIDTH
//   stb_in   input sample valid
//   xo, yo   rotated vector = (K/2) * rotation, saturated to WIDTH bits
//   zo       residual angle after the last stage (close to 0)
//   stb_out  output sample valid (stb_in delayed by STAGES+2)
module cordic_rotator #(
    parameter int WIDTH  = 16,
    parameter int ZWIDTH = 24,
    parameter int STAGES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  xi,
    input  logic [WIDTH-1:0]  yi,
    input  logic [ZWIDTH-1:0] zi,
    input  logic              stb_in,
    output logic [WIDTH-1:0]  xo,
    output logic [WIDTH-1:0]  yo,
    output logic [ZWIDTH-1:0] zo,
    output logic              stb_out
);

    // Two guard bits absorb the CORDIC gain (K ~ 1.647) on a full-scale vector.
    localparam int IW = WIDTH + 2;

    localparam logic [ZWIDTH-1:0]    HALF_TURN = {1'b1, {(ZWIDTH-1){1'b0}}};
    localparam logic signed [IW-1:0] OUT_MAX   = IW'((2 ** (WIDTH-1)) - 1);
    localparam logic signed [IW-1:0] OUT_MIN   = IW'(-(2 ** (WIDTH-1)));

    // atan(2^-i) in units of 2^-24 of a turn. This table assumes a 24-bit phase.
    function automatic logic signed [ZWIDTH-1:0] atan_lut(input int idx);
        logic [ZWIDTH-1:0] a;
        case (idx)
            0:       a = ZWIDTH'(2097152);
            1:       a = ZWIDTH'(1238021);
            2:       a = ZWIDTH'(654136);
            3:       a = ZWIDTH'(332050);
            4:       a = ZWIDTH'(166669);
            5:       a = ZWIDTH'(83416);
            6:       a = ZWIDTH'(41718);
            7:       a = ZWIDTH'(20860);
            8:       a = ZWIDTH'(10430);
            9:       a = ZWIDTH'(5215);
            10:      a = ZWIDTH'(2608);
            11:      a = ZWIDTH'(1304);
            12:      a = ZWIDTH'(652);
            13:      a = ZWIDTH'(326);
            14:      a = ZWIDTH'(163);
            15:      a = ZWIDTH'(81);
            16:      a = ZWIDTH'(41);
            17:      a = ZWIDTH'(20);
            18:      a = ZWIDTH'(10);
            19:      a = ZWIDTH'(5);
            20:      a = ZWIDTH'(3);
            21:      a = ZWIDTH'(1);
            22:      a = ZWIDTH'(1);
            default: a = '0;
        endcase
        return a;
    endfunction

    // Drops the extra gain bit, then clips to the external sample range.
    function automatic logic [WIDTH-1:0] sat_half(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] h;
        h = v >>> 1;
        if (h > OUT_MAX) begin
            return OUT_MAX[WIDTH-1:0];
        end else if (h < OUT_MIN) begin
            return OUT_MIN[WIDTH-1:0];
        end
        return h[WIDTH-1:0];
    endfunction

    // Capture register.
    logic [WIDTH-1:0]  xi_q, yi_q;
    logic [ZWIDTH-1:0] zi_q;
    logic              in_vld_q;

    // Index 0 is the pre-rotation register; index i+1 is the output of stage i.
    logic signed [IW-1:0]     x_q [STAGES+1];
    logic signed [IW-1:0]     y_q [STAGES+1];
    logic signed [ZWIDTH-1:0] z_q [STAGES+1];
    logic [STAGES:0]          vld_q;

    logic signed [IW-1:0]     x_pre, y_pre, x_ext, y_ext;
    logic signed [ZWIDTH-1:0] z_pre;

    logic signed [IW-1:0]     x_d [STAGES];
    logic signed [IW-1:0]     y_d [STAGES];
    logic signed [ZWIDTH-1:0] z_d [STAGES];

    // The micro-rotations only converge for |angle| < ~99.9 deg. Angles in
    // the second and third quadrants are therefore turned by 180 deg first.
    // The 180 deg turn negates the vector and subtracts a half turn from z.
    // The two guard bits keep -(-2^(WIDTH-1)) exact.
    always_comb begin
        x_ext = IW'($signed(xi_q));
        y_ext = IW'($signed(yi_q));
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = $signed(zi_q);
        if (zi_q[ZWIDTH-1] ^ zi_q[ZWIDTH-2]) begin
            x_pre = -x_ext;
            y_pre = -y_ext;
            z_pre = $signed(zi_q - HALF_TURN);
        end
    end

    // Each stage rotates by the angle +/-atan(2^-i). The sign is chosen to
    // drive the remaining angle z towards zero.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            if (z_q[i][ZWIDTH-1]) begin
                x_d[i] = x_q[i] + (y_q[i] >>> i);
                y_d[i] = y_q[i] - (x_q[i] >>> i);
                z_d[i] = z_q[i] + atan_lut(i);
            end else begin
                x_d[i] = x_q[i] - (y_q[i] >>> i);
                y_d[i] = y_q[i] + (x_q[i] >>> i);
                z_d[i] = z_q[i] - atan_lut(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xi_q     <= '0;
            yi_q     <= '0;
            zi_q     <= '0;
            in_vld_q <= 1'b0;
            for (int i = 0; i <= STAGES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
            end
            vld_q    <= '0;
            xo       <= '0;
            yo       <= '0;
            zo       <= '0;
            stb_out  <= 1'b0;
        end else begin
            xi_q     <= xi;
            yi_q     <= yi;
            zi_q     <= zi;
            in_vld_q <= stb_in;
            x_q[0]   <= x_pre;
            y_q[0]   <= y_pre;
            z_q[0]   <= z_pre;
            for (int i = 0; i < STAGES; i++) begin
                x_q[i+1] <= x_d[i];
                y_q[i+1] <= y_d[i];
                z_q[i+1] <= z_d[i];
            end
            vld_q    <= {vld_q[STAGES-1:0], in_vld_q};
            xo       <= sat_half(x_q[STAGES]);
            yo       <= sat_half(y_q[STAGES]);
            zo       <= z_q[STAGES];
            stb_out  <= vld_q[STAGES];
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator.
// The stimulus process pushes the ideal (K/2)-scaled rotation of each strobed
// sample, computed with real trigonometry. A monitor process pops and compares
// each entry whenever stb_out is seen. The monitor also checks the reset,
// idle and missing-output conditions.
module tb_cordic_rotator;

    localparam int  WIDTH  = 16;
    localparam int  ZWIDTH = 24;
    localparam int  STAGES = 16;
    localparam int  LAT    = STAGES + 2;
    localparam real TOL    = 4.0;
    localparam real ZTOL   = 128.0;
    localparam real TWO_PI = 6.283185307179586;

    logic              clk    = 1'b0;
    logic              rst    = 1'b0;
    logic [WIDTH-1:0]  xi     = '0;
    logic [WIDTH-1:0]  yi     = '0;
    logic [ZWIDTH-1:0] zi     = '0;
    logic              stb_in = 1'b0;
    logic [WIDTH-1:0]  xo;
    logic [WIDTH-1:0]  yo;
    logic [ZWIDTH-1:0] zo;
    logic              stb_out;

    cordic_rotator #(
        .WIDTH  (WIDTH),
        .ZWIDTH (ZWIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .xi      (xi),
        .yi      (yi),
        .zi      (zi),
        .stb_in  (stb_in),
        .xo      (xo),
        .yo      (yo),
        .zo      (zo),
        .stb_out (stb_out)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        real x;
        real y;
        int  due;
    } exp_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    real  gain      = 0.0;
    bit   chk_idle  = 1'b0;
    exp_t mon_e;
    real  gx, gy, gz;

    function automatic real sat(input real v);
        if (v > 32767.0) return 32767.0;
        if (v < -32768.0) return -32768.0;
        return v;
    endfunction

    function automatic real absr(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic check(input string name, input bit ok, input real got, input real want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0.2f required %0.2f (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    // Drives one cycle of input. A strobed sample queues its ideal result.
    task automatic drive(input int x, input int y, input int z, input bit s);
        exp_t e;
        real  th;
        @(negedge clk);
        xi     = x[WIDTH-1:0];
        yi     = y[WIDTH-1:0];
        zi     = z[ZWIDTH-1:0];
        stb_in = s;
        if (s) begin
            th    = real'(z & 32'h00FF_FFFF) * TWO_PI / 16777216.0;
            e.x   = sat(gain * (real'(x) * $cos(th) - real'(y) * $sin(th)));
            e.y   = sat(gain * (real'(x) * $sin(th) + real'(y) * $cos(th)));
            e.due = edge_cnt + 1 + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1'b0);
    endtask

    // Monitor: samples 1 time unit after each falling clock edge and after a reset assertion.
    always begin
        @(negedge clk or negedge rst);
        #1;
        gx = real'(int'($signed(xo)));
        gy = real'(int'($signed(yo)));
        gz = real'(int'($signed(zo)));
        if (!rst) begin
            check("reset_xo", xo == '0, gx, 0.0);
            check("reset_yo", yo == '0, gy, 0.0);
            check("reset_zo", zo == '0, gz, 0.0);
            check("reset_stb_out", stb_out == 1'b0, real'(stb_out), 0.0);
        end else if (stb_out) begin
            if (sb.size() == 0) begin
                check("spurious_stb_out", 1'b0, 1.0, 0.0);
            end else begin
                mon_e = sb.pop_front();
                check("latency", edge_cnt == mon_e.due, real'(edge_cnt), real'(mon_e.due));
                check("xo", absr(gx - mon_e.x) <= TOL, gx, mon_e.x);
                check("yo", absr(gy - mon_e.y) <= TOL, gy, mon_e.y);
                check("zo_residual", absr(gz) <= ZTOL, gz, 0.0);
            end
        end else begin
            if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                mon_e = sb.pop_front();
                check("missing_stb_out", 1'b0, 0.0, real'(mon_e.due));
            end
            if (chk_idle) begin
                check("idle_xo", xo == '0, gx, 0.0);
                check("idle_yo", yo == '0, gy, 0.0);
                check("idle_zo_residual", absr(gz) <= ZTOL, gz, 0.0);
            end
        end
    end

    initial begin
        real p;
        real f;
        p = 1.0;
        f = 1.0;
        for (int i = 0; i < STAGES; i++) begin
            p = p * $sqrt(1.0 + f * f);
            f = f / 2.0;
        end
        gain = p / 2.0;

        // Reset, then idle with zero inputs and no strobes.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_idle = 1'b1;
        idle(100);
        chk_idle = 1'b0;

        // Zero rotation, then the three other quadrant axes.
        drive(16384, 0, 0, 1'b1);
        idle(LAT + 4);
        drive(16384, 0, 1 << 22, 1'b1);
        drive(16384, 0, 1 << 23, 1'b1);
        drive(16384, 0, 3 << 22, 1'b1);
        idle(LAT + 4);

        // Back-to-back throughput sweep.
        for (int k = 0; k < 64; k++) drive(16384, 0, k << 20, 1'b1);
        idle(4);

        // Saturation and the most negative input.
        drive(32767, 32767, 1 << 21, 1'b1);
        drive(-32768, 0, 1 << 23, 1'b1);
        drive(32767, -32768, 3 << 21, 1'b1);
        idle(LAT + 4);

        // Random vectors and phases with random strobe gaps.
        for (int n = 0; n < 300; n++) begin
            drive(int'($urandom_range(0, 32767)) - 16384,
                  int'($urandom_range(0, 32767)) - 16384,
                  int'($urandom_range(0, 24'hFF_FFFF)),
                  $urandom_range(0, 3) != 0);
        end
        idle(LAT + 4);

        // Reset while ten samples are in flight. None of them may emerge.
        for (int n = 0; n < 10; n++) begin
            drive(int'($urandom_range(0, 32767)) - 16384, 12345,
                  int'($urandom_range(0, 24'hFF_FFFF)), 1'b1);
        end
        idle(2);
        #2;
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_idle = 1'b1;
        idle(40);
        chk_idle = 1'b0;

        // New strobes after reset are processed normally.
        drive(-16384, 0, 0, 1'b1);
        drive(0, 16384, 1 << 22, 1'b1);
        idle(LAT + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
